unary_add_nch: RTL
==================

# unary_add_nch

Parametrised unary-stream accumulator for the unary adder family. It sums 1-bits arriving on `N_IN` serial unary input channels into a `CNT_W`-bit count, with selectable saturating or wrapping overflow. On command it replays the accumulated total as a unary burst on `dout` and flags completion. It is the generalised successor of the fixed two-input, 0..7 unary adder, adding more channels, count width, an overflow mode and a drain-complete handshake.

## Interface
**Parameters**
- `N_IN`, default 2: number of unary input channels; must be ≥1.
- `CNT_W`, default 3: count width; MAX = 2^CNT_W − 1.
- `SAT`, default 1: overflow mode. 1 clamps the count at MAX; 0 wraps it modulo 2^CNT_W.

**Ports**
- `clk` in, 1: sole clock; all state updates on its rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `en` in, 1: global enable. When 0, all state holds and `dout` is driven 0.
- `read_or_write` in, 1: 0 = accumulate (write); 1 = drain (read).
- `din` in, N_IN: one unary bit per channel per cycle.
- `dout` out, 1: unary replay of the count; registered.
- `C` out, 1: sticky overflow flag; registered.
- `done` out, 1: drain complete; registered, level until the next accumulate.
- `count` out, CNT_W: current count; registered, for observation.

## Operation
- **FSM states:** IDLE, ACC, DRAIN, DONE.
- **Reset:** state = IDLE; `count`, `dout`, `C`, `done` all 0.
- **`en` = 0:** in any state, state/`count`/`C`/`done` hold and `dout` ← 0.
- **IDLE:**
  - `en` & !`read_or_write` → ACC, and `din` is accumulated on that same edge.
  - `en` & `read_or_write` → DRAIN.
- **ACC, `read_or_write` = 0:**
  - sum = `count` + popcount(`din`), computed in max(CNT_W, clog2(N_IN+1)) + 1 bits.
  - sum > MAX, SAT = 1: `count` ← MAX and `C` ← 1.
  - sum > MAX, SAT = 0: `count` ← sum mod 2^CNT_W and `C` ← 1.
  - Otherwise `count` ← sum.
- **ACC, `read_or_write` = 1:** → DRAIN. `din` is NOT accumulated on this edge.
- **DRAIN:**
  - `count` > 0: `dout` ← 1 and `count` ← `count` − 1.
  - `count` = 0: `dout` ← 0, `done` ← 1, → DONE.
  - `read_or_write` is ignored in DRAIN; the drain is atomic and only `en` = 0 or `rst` interrupts it.
- **DONE:**
  - `en` & !`read_or_write` → ACC, clearing `done` and `C` and accumulating `din` on that edge.
  - Otherwise hold.
- **Overflow in SAT = 0 mode:** a total of exactly 2^CNT_W wraps to 0, so a drain emits no pulses, but `C` = 1 still reports the overflow.

## Timing
- Accumulate latency: `din` sampled at edge e appears in `count` after e.
- Drain sequence, with edge e0 being the one that samples `read_or_write` = 1 and enters DRAIN:
  - `dout` is high after edges e1..eN, where N is the count at e0.
  - `done` rises after edge e(N+1).
  - Total: N+1 cycles from e0.
  - N = 0 gives `done` after e1 with no `dout` pulse.
- `en` deasserted mid-drain stretches the burst. The pulses remain N in total, but `dout` is 0 during paused cycles.
- `rst` mid-operation clears everything on the same edge; a partially emitted burst is abandoned.
- `rst` has priority over `en`.

## Structure
- **Package `unary_add_pkg`:** FSM state enum `state_t` (IDLE, ACC, DRAIN, DONE) and the popcount-width helper function.
- **Sub-module `unary_popcount`:** combinational popcount of `N_IN` bits, output width clog2(N_IN+1).
- **Top level:** the FSM plus the saturate/wrap accumulator.

## Test plan
- **Basic sum** (defaults): `din` = 2'b11 for 3 cycles, then `read_or_write` = 1 → `count` = 6, `dout` high for exactly 6 consecutive cycles, `done` = 1 one cycle after that, `C` = 0.
- **Saturation** (SAT = 1): `din` = 2'b11 for 4 cycles → `count` = 7, `C` = 1; drain gives exactly 7 `dout` pulses.
- **Wrap** (SAT = 0): `din` = 2'b11 for 4 cycles → `count` = 0, `C` = 1; drain gives no `dout` pulse and `done` one edge after entering DRAIN. Also `din` = 2'b11 for 5 cycles → `count` = 2, giving 2 pulses.
- **Wide, mixed channels** (N_IN = 4, CNT_W = 5): `din` = 4'b1011, 4'b0001, 4'b1111 → `count` = 8; set `read_or_write` = 1 in the same cycle as a `din` = 4'b1111 → that `din` is ignored and exactly 8 pulses follow.
- **Pause/abort:**
  - With `count` = 5, drop `en` for 3 cycles after the 2nd pulse → total 5 pulses and `dout` = 0 while paused.
  - Assert `rst` after the 2nd pulse → `count`, `dout`, `C`, `done` = 0 next cycle and state = IDLE.
- **Re-arm:** after DONE with `C` = 1, set `read_or_write` = 0 with `din` = 2'b01 → `done` = 0, `C` = 0, `count` = 1 after that edge.

Source files
------------

// File: rtl/unary_add_pkg.sv
// Shared types and width helpers for the unary adder family.
package unary_add_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Bits needed to hold a popcount of n inputs (0..n).
   function automatic int pc_width(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/unary_popcount.sv
// Combinational population count of the unary input channels.
module unary_popcount
   import unary_add_pkg::*;
#(
   parameter int N_IN = 2,
   parameter int PC_W = pc_width(N_IN)
) (
   input  logic [N_IN-1:0] din,
   output logic [PC_W-1:0] cnt
);

   // Sum of the set bits across all channels.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < N_IN; i++) begin
         cnt = cnt + PC_W'(din[i]);
      end
   end

endmodule

// File: rtl/unary_add_nch.sv
// Multi-channel unary accumulator with saturating/wrapping count and a
// unary replay (drain) of the accumulated total.
//
// state | meaning
// IDLE  | after reset, nothing accumulated yet
// ACC   | summing popcount(din) into count each enabled cycle
// DRAIN | emitting one dout pulse per unit of count, atomic until empty
// DONE  | burst finished, done held high until the next accumulate
module unary_add_nch
   import unary_add_pkg::*;
#(
   parameter int N_IN  = 2,
   parameter int CNT_W = 3,
   parameter int SAT   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             read_or_write,
   input  logic [N_IN-1:0]  din,
   output logic             dout,
   output logic             C,
   output logic             done,
   output logic [CNT_W-1:0] count
);

   localparam int PC_W  = pc_width(N_IN);
   // One guard bit above the wider operand so the overflow is visible.
   localparam int SUM_W = max_int(CNT_W, PC_W) + 1;
   localparam logic [SUM_W-1:0] MAX_S = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               dout_q, dout_d;
   logic               c_q, c_d;
   logic               done_q, done_d;

   logic [PC_W-1:0]    pc;
   logic [SUM_W-1:0]   sum;
   logic [CNT_W-1:0]   acc_count;
   logic               acc_ovf;

   unary_popcount #(
      .N_IN (N_IN),
      .PC_W (PC_W)
   ) u_popcount (
      .din (din),
      .cnt (pc)
   );

   // Candidate accumulate result with saturate or wrap on overflow.
   always_comb begin
      sum       = {{(SUM_W-CNT_W){1'b0}}, count_q} + {{(SUM_W-PC_W){1'b0}}, pc};
      acc_ovf   = (sum > MAX_S);
      acc_count = sum[CNT_W-1:0];
      if (acc_ovf && (SAT != 0)) begin
         acc_count = {CNT_W{1'b1}};
      end
   end

   // Next-state and output logic; en low freezes everything and silences dout.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      dout_d  = 1'b0;
      c_d     = c_q;
      done_d  = done_q;
      if (en) begin
         case (state_q)
            IDLE: begin
               if (!read_or_write) begin
                  state_d = ACC;
                  count_d = acc_count;
                  c_d     = c_q | acc_ovf;
               end else begin
                  state_d = DRAIN;
               end
            end
            ACC: begin
               if (!read_or_write) begin
                  count_d = acc_count;
                  c_d     = c_q | acc_ovf;
               end else begin
                  // din on the switching edge is deliberately dropped
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (count_q != '0) begin
                  dout_d  = 1'b1;
                  count_d = count_q - CNT_W'(1);
               end else begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
            DONE: begin
               if (!read_or_write) begin
                  // count is already 0 here, so this starts a fresh total
                  state_d = ACC;
                  done_d  = 1'b0;
                  count_d = acc_count;
                  c_d     = acc_ovf;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         dout_q  <= 1'b0;
         c_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         dout_q  <= dout_d;
         c_q     <= c_d;
         done_q  <= done_d;
      end
   end

   assign dout  = dout_q;
   assign C     = c_q;
   assign done  = done_q;
   assign count = count_q;

endmodule
